// File: rtl/avg_reduce_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : avg_reduce_sched_pkg
// Description : Shared types and helpers for the averaging-reduction
//               controller. These are the controller state encoding, the
//               log2 helper and the datapath width rule.
// Revision    : 1.0 - initial release
// ============================================================================
package avg_reduce_sched_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        REDUCE = 2'd1,
        DRAIN  = 2'd2,
        OUT    = 2'd3
    } state_e;

    // The datapath is twice the base sample width.
    localparam int W_SHIFT = 1;

    function automatic int clog2(input int value);
        int result;
        int power;
        result = 0;
        power  = 1;
        while (power < value) begin
            power  = power << 1;
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int datapath_w(input int data_width);
        return data_width << W_SHIFT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/avg_reduce_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : avg_reduce_sched_if
// Description : Sample input, result output and control bundle of the
//               averaging-reduction controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface avg_reduce_sched_if #(
    parameter int W = 32
);
    logic         clr;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;

    modport master (
        output clr, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  clr, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/avg_reduce_sched_avg_pair.sv
`default_nettype none
// ============================================================================
// Module      : avg_pair
// Description : Single registered pairwise-averaging stage. It computes the
//               signed mean of a and b in W+1 bits, so overflow cannot occur.
//               Macro AVG_REDUCE_ROUND_EN selects round-half-up instead of
//               floor.
// Revision    : 1.0 - initial release
// ============================================================================
module avg_pair #(
    parameter int W = 32
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         en,
    input  wire logic [W-1:0] a,
    input  wire logic [W-1:0] b,
    output logic      [W-1:0] y
);

`ifdef AVG_REDUCE_ROUND_EN
    localparam logic [W:0] ROUND_BIAS = (W+1)'(1);
`else
    localparam logic [W:0] ROUND_BIAS = '0;
`endif

    logic [W:0] sum;

    // Sign-extend both operands by one bit so that the sum always fits.
    assign sum = {a[W-1], a} + {b[W-1], b} + ROUND_BIAS;

    // Halve the sum arithmetically and register it. The value is held while the stage is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= '0;
        end else if (en) begin
            y <= W'($signed(sum) >>> 1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/avg_reduce_sched.sv
`default_nettype none
// ============================================================================
// Module      : avg_reduce_sched
// Description : Time-multiplexed averaging-reduction controller. It buffers
//               NUM_IN samples, then uses one shared averaging stage level by
//               level to reduce them until a single frame average remains.
//               The average is presented on a valid/ready output.
//               Optional macro: AVG_REDUCE_ROUND_EN (round half up).
// Revision    : 1.0 - initial release
// ============================================================================
module avg_reduce_sched
    import avg_reduce_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_IN     = 8
) (
    input wire logic           clk,
    input wire logic           rst_n,
    avg_reduce_sched_if.slave  bus
);

    localparam int W   = datapath_w(DATA_WIDTH);
    localparam int LVL = clog2(NUM_IN);

    localparam logic [1:0] S_LOAD   = LOAD;
    localparam logic [1:0] S_REDUCE = REDUCE;
    localparam logic [1:0] S_DRAIN  = DRAIN;
    localparam logic [1:0] S_OUT    = OUT;

    localparam logic [LVL-1:0] CNT_LAST = LVL'(NUM_IN - 1);
    localparam logic [LVL-1:0] NPAIRS0  = LVL'(NUM_IN / 2);
    localparam logic [LVL-1:0] ONE      = LVL'(1);

    logic [1:0]     state;
    logic [LVL-1:0] cnt;
    logic [LVL-1:0] pair_idx;
    logic [LVL-1:0] npairs;
    logic           pipe_valid;
    logic [LVL-1:0] pipe_idx;
    logic [W-1:0]   sbuf [NUM_IN];

    logic           issue;
    logic           load_accept;
    logic [LVL-1:0] rd0;
    logic [LVL-1:0] rd1;
    logic [W-1:0]   pair_y;

    assign issue       = (state == S_REDUCE);
    assign load_accept = (state == S_LOAD) && bus.in_valid;

    // Pair j reads the adjacent slots 2j and 2j+1. The write back to slot j
    // never overtakes a read that is still pending in the same level.
    assign rd0 = pair_idx << 1;
    assign rd1 = rd0 | ONE;

    assign bus.in_ready  = (state == S_LOAD);
    assign bus.out_valid = (state == S_OUT);
    assign bus.busy      = (state != S_LOAD);
    assign bus.out_data  = sbuf[0];

    avg_pair #(
        .W (W)
    ) u_pair (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (issue),
        .a     (sbuf[rd0]),
        .b     (sbuf[rd1]),
        .y     (pair_y)
    );

    // Controller: frame load, per-level pair issue, a drain cycle per level, then the result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_LOAD;
            cnt        <= '0;
            pair_idx   <= '0;
            npairs     <= NPAIRS0;
            pipe_valid <= 1'b0;
            pipe_idx   <= '0;
        end else if (bus.clr) begin
            state      <= S_LOAD;
            cnt        <= '0;
            pair_idx   <= '0;
            npairs     <= NPAIRS0;
            pipe_valid <= 1'b0;
        end else begin
            pipe_valid <= issue;
            pipe_idx   <= pair_idx;
            case (state)
                S_LOAD: begin
                    if (bus.in_valid) begin
                        cnt <= cnt + ONE;
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= S_REDUCE;
                        end
                    end
                end
                S_REDUCE: begin
                    pair_idx <= pair_idx + ONE;
                    if (pair_idx == npairs - ONE) begin
                        pair_idx <= '0;
                        state    <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (npairs == ONE) begin
                        state <= S_OUT;
                    end else begin
                        npairs <= npairs >> 1;
                        state  <= S_REDUCE;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        cnt    <= '0;
                        npairs <= NPAIRS0;
                        state  <= S_LOAD;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    // Sample buffer: filled in LOAD and overwritten in place by the averaging results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_IN; i++) begin
                sbuf[i] <= '0;
            end
        end else if (!bus.clr) begin
            if (load_accept) begin
                sbuf[cnt] <= bus.in_data;
            end
            if (pipe_valid) begin
                sbuf[pipe_idx] <= pair_y;
            end
        end
    end

endmodule
`default_nettype wire
